// File: rtl/vdp_pkg.sv
// Shared VDP definitions: access codes, prefetch FSM states and default widths.
package vdp_pkg;

  localparam int unsigned VRAM_AW_DEF = 14;
  localparam int unsigned CRAM_AW_DEF = 5;

  localparam logic [1:0] CODE_VRD  = 2'd0;
  localparam logic [1:0] CODE_VWR  = 2'd1;
  localparam logic [1:0] CODE_REG  = 2'd2;
  localparam logic [1:0] CODE_CRAM = 2'd3;

  typedef enum logic [1:0] {
    StIdle,
    StRdAddr,
    StRdWait,
    StRdCap
  } pf_state_e;

endpackage

// File: rtl/vdp_cpu_port_if.sv
// Z80-side access bus of the VDP: strobe, direction, port select, data and busy.
interface vdp_cpu_port_if;
  logic       cpu_sel;
  logic       cpu_wr;
  logic       cpu_a0;
  logic [7:0] cpu_din;
  logic [7:0] cpu_dout;
  logic       cpu_busy;

  modport master (
    output cpu_sel, cpu_wr, cpu_a0, cpu_din,
    input  cpu_dout, cpu_busy
  );

  modport slave (
    input  cpu_sel, cpu_wr, cpu_a0, cpu_din,
    output cpu_dout, cpu_busy
  );
endinterface

// File: rtl/vdp_cpu_port.sv
// CPU access controller of the VDP: address/code latch, control toggle, read-ahead
// buffer and VRAM prefetch sequencer driving port A of the VRAM dpram.
module vdp_cpu_port
  import vdp_pkg::*;
#(
  parameter int unsigned VRAM_AW = VRAM_AW_DEF,
  parameter int unsigned CRAM_AW = CRAM_AW_DEF
) (
  input  logic               clk,
  input  logic               reset,
  vdp_cpu_port_if.slave      cpu,
  input  logic [7:0]         status_in,
  output logic               status_rd,
  output logic [VRAM_AW-1:0] vram_addr,
  output logic [7:0]         vram_din,
  output logic               vram_we,
  input  logic [7:0]         vram_q,
  output logic [CRAM_AW-1:0] cram_addr,
  output logic [7:0]         cram_din,
  output logic               cram_we,
  output logic [3:0]         reg_num,
  output logic [7:0]         reg_val,
  output logic               reg_we
);

  pf_state_e          state_q, state_d;
  logic [VRAM_AW-1:0] addr_q, addr_d;
  logic [1:0]         code_q, code_d;
  logic               second_q, second_d;
  logic [7:0]         rbuf_q, rbuf_d;
  logic [7:0]         dout_q, dout_d;
  logic               status_rd_q, status_rd_d;
  logic [VRAM_AW-1:0] vram_addr_q, vram_addr_d;
  logic [7:0]         vram_din_q, vram_din_d;
  logic               vram_we_q, vram_we_d;
  logic [CRAM_AW-1:0] cram_addr_q, cram_addr_d;
  logic [7:0]         cram_din_q, cram_din_d;
  logic               cram_we_q, cram_we_d;
  logic [3:0]         reg_num_q, reg_num_d;
  logic [7:0]         reg_val_q, reg_val_d;
  logic               reg_we_q, reg_we_d;
  logic               vram_wr;
  logic [13:0]        hi_addr;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    code_d      = code_q;
    second_d    = second_q;
    rbuf_d      = rbuf_q;
    dout_d      = dout_q;
    status_rd_d = 1'b0;
    vram_din_d  = vram_din_q;
    vram_we_d   = 1'b0;
    cram_addr_d = cram_addr_q;
    cram_din_d  = cram_din_q;
    cram_we_d   = 1'b0;
    reg_num_d   = reg_num_q;
    reg_val_d   = reg_val_q;
    reg_we_d    = 1'b0;
    vram_wr     = 1'b0;
    hi_addr     = {cpu.cpu_din[5:0], addr_q[7:0]};

    unique case (state_q)
      StRdAddr: state_d = StRdWait;
      StRdWait: state_d = StRdCap;
      StRdCap: begin
        rbuf_d  = vram_q;
        addr_d  = addr_q + 1'b1;
        state_d = StIdle;
      end
      default: begin
        // Strobes are only accepted while idle; busy strobes leave no trace.
        if (cpu.cpu_sel) begin
          if (cpu.cpu_wr && cpu.cpu_a0) begin
            if (!second_q) begin
              addr_d[7:0] = cpu.cpu_din;
              second_d    = 1'b1;
            end else begin
              addr_d   = hi_addr[VRAM_AW-1:0];
              code_d   = cpu.cpu_din[7:6];
              second_d = 1'b0;
              if (cpu.cpu_din[7:6] == CODE_VRD) state_d = StRdAddr;
              if (cpu.cpu_din[7:6] == CODE_REG) begin
                reg_we_d  = 1'b1;
                reg_num_d = cpu.cpu_din[3:0];
                reg_val_d = addr_q[7:0];
              end
            end
          end else if (cpu.cpu_wr) begin
            second_d = 1'b0;
            rbuf_d   = cpu.cpu_din;
            if (code_q == CODE_CRAM) begin
              cram_we_d   = 1'b1;
              cram_addr_d = addr_q[CRAM_AW-1:0];
              cram_din_d  = cpu.cpu_din;
            end else begin
              vram_wr    = 1'b1;
              vram_we_d  = 1'b1;
              vram_din_d = cpu.cpu_din;
            end
            addr_d = addr_q + 1'b1;
          end else if (!cpu.cpu_a0) begin
            dout_d   = rbuf_q;
            second_d = 1'b0;
            state_d  = StRdAddr;
          end else begin
            dout_d      = status_in;
            status_rd_d = 1'b1;
            second_d    = 1'b0;
          end
        end
      end
    endcase

    // The port tracks the latch except during the write pulse itself.
    vram_addr_d = vram_wr ? addr_q : addr_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      addr_q      <= '0;
      code_q      <= '0;
      second_q    <= 1'b0;
      rbuf_q      <= '0;
      dout_q      <= '0;
      status_rd_q <= 1'b0;
      vram_addr_q <= '0;
      vram_din_q  <= '0;
      vram_we_q   <= 1'b0;
      cram_addr_q <= '0;
      cram_din_q  <= '0;
      cram_we_q   <= 1'b0;
      reg_num_q   <= '0;
      reg_val_q   <= '0;
      reg_we_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      code_q      <= code_d;
      second_q    <= second_d;
      rbuf_q      <= rbuf_d;
      dout_q      <= dout_d;
      status_rd_q <= status_rd_d;
      vram_addr_q <= vram_addr_d;
      vram_din_q  <= vram_din_d;
      vram_we_q   <= vram_we_d;
      cram_addr_q <= cram_addr_d;
      cram_din_q  <= cram_din_d;
      cram_we_q   <= cram_we_d;
      reg_num_q   <= reg_num_d;
      reg_val_q   <= reg_val_d;
      reg_we_q    <= reg_we_d;
    end
  end

  assign cpu.cpu_dout = dout_q;
  assign cpu.cpu_busy = (state_q != StIdle);
  assign status_rd    = status_rd_q;
  assign vram_addr    = vram_addr_q;
  assign vram_din     = vram_din_q;
  assign vram_we      = vram_we_q;
  assign cram_addr    = cram_addr_q;
  assign cram_din     = cram_din_q;
  assign cram_we      = cram_we_q;
  assign reg_num      = reg_num_q;
  assign reg_val      = reg_val_q;
  assign reg_we       = reg_we_q;

endmodule

// File: tb/tb_vdp_cpu_port.sv
// Directed bench for vdp_cpu_port with a behavioural one-cycle-latency VRAM model.
module tb_vdp_cpu_port;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  status_in = 8'h00;
  logic        status_rd;
  logic [13:0] vram_addr;
  logic [7:0]  vram_din;
  logic        vram_we;
  logic [7:0]  vram_q;
  logic [4:0]  cram_addr;
  logic [7:0]  cram_din;
  logic        cram_we;
  logic [3:0]  reg_num;
  logic [7:0]  reg_val;
  logic        reg_we;
  logic [7:0]  mem [0:16383];
  int          tests_run = 0;
  int          tests_failed = 0;
  int          cyc;

  vdp_cpu_port_if cpu_if ();

  vdp_cpu_port dut (
    .clk       (clk),
    .reset     (reset),
    .cpu       (cpu_if),
    .status_in (status_in),
    .status_rd (status_rd),
    .vram_addr (vram_addr),
    .vram_din  (vram_din),
    .vram_we   (vram_we),
    .vram_q    (vram_q),
    .cram_addr (cram_addr),
    .cram_din  (cram_din),
    .cram_we   (cram_we),
    .reg_num   (reg_num),
    .reg_val   (reg_val),
    .reg_we    (reg_we)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (vram_we) mem[vram_addr] <= vram_din;
    vram_q <= mem[vram_addr];
  end

  task automatic strobe(input logic wr, input logic a0, input logic [7:0] din);
    @(posedge clk); #1;
    cpu_if.cpu_sel = 1'b1; cpu_if.cpu_wr = wr; cpu_if.cpu_a0 = a0; cpu_if.cpu_din = din;
    @(posedge clk); #1;
    cpu_if.cpu_sel = 1'b0; cpu_if.cpu_wr = 1'b0; cpu_if.cpu_a0 = 1'b0; cpu_if.cpu_din = 8'h00;
  endtask

  task automatic wait_idle(output int cycles);
    cycles = 0;
    while (cpu_if.cpu_busy && cycles < 20) begin
      @(posedge clk); #1;
      cycles++;
    end
  endtask

  task automatic test_reset();
    tests_run++;
    if ({vram_addr, vram_we, cram_we, reg_we, status_rd, cpu_if.cpu_busy} !== 19'h0) begin
      tests_failed++;
      $display("FAIL reset_ctrl: got addr=%h we=%b cwe=%b rwe=%b srd=%b busy=%b want all 0",
               vram_addr, vram_we, cram_we, reg_we, status_rd, cpu_if.cpu_busy);
    end
    tests_run++;
    if (cpu_if.cpu_dout !== 8'h00) begin
      tests_failed++; $display("FAIL reset_dout: got %h want 00", cpu_if.cpu_dout);
    end
  endtask

  task automatic test_ctrl_latch();
    strobe(1'b1, 1'b1, 8'h34);
    tests_run++;
    if (vram_addr !== 14'h0034 || vram_we !== 1'b0) begin
      tests_failed++; $display("FAIL ctrl_low: got addr=%h we=%b want 0034/0", vram_addr, vram_we);
    end
    strobe(1'b1, 1'b1, 8'h52);
    tests_run++;
    if (vram_addr !== 14'h1234 || {vram_we, cram_we, reg_we, cpu_if.cpu_busy} !== 4'b0) begin
      tests_failed++;
      $display("FAIL ctrl_high: got addr=%h we=%b cwe=%b rwe=%b busy=%b want 1234/0/0/0/0",
               vram_addr, vram_we, cram_we, reg_we, cpu_if.cpu_busy);
    end
  endtask

  task automatic test_data_write();
    strobe(1'b1, 1'b0, 8'hAA);
    tests_run++;
    if (vram_we !== 1'b1 || vram_addr !== 14'h1234 || vram_din !== 8'hAA) begin
      tests_failed++;
      $display("FAIL wr_aa: got we=%b addr=%h din=%h want 1/1234/aa", vram_we, vram_addr, vram_din);
    end
    strobe(1'b1, 1'b0, 8'hBB);
    tests_run++;
    if (vram_we !== 1'b1 || vram_addr !== 14'h1235 || vram_din !== 8'hBB) begin
      tests_failed++;
      $display("FAIL wr_bb: got we=%b addr=%h din=%h want 1/1235/bb", vram_we, vram_addr, vram_din);
    end
    @(posedge clk); #1;
    tests_run++;
    if (vram_we !== 1'b0 || vram_addr !== 14'h1236) begin
      tests_failed++; $display("FAIL wr_after: got we=%b addr=%h want 0/1236", vram_we, vram_addr);
    end
  endtask

  task automatic test_prefetch();
    strobe(1'b1, 1'b1, 8'h00);
    strobe(1'b1, 1'b1, 8'h60);
    strobe(1'b1, 1'b0, 8'h5A);
    strobe(1'b1, 1'b0, 8'hC3);
    strobe(1'b1, 1'b1, 8'h00);
    strobe(1'b1, 1'b1, 8'h20);
    tests_run++;
    if (cpu_if.cpu_busy !== 1'b1 || vram_addr !== 14'h2000 || vram_we !== 1'b0) begin
      tests_failed++;
      $display("FAIL pf_start: got busy=%b addr=%h we=%b want 1/2000/0",
               cpu_if.cpu_busy, vram_addr, vram_we);
    end
    wait_idle(cyc);
    tests_run++;
    if (cyc !== 3 || vram_addr !== 14'h2001) begin
      tests_failed++; $display("FAIL pf_len: got cycles=%0d addr=%h want 3/2001", cyc, vram_addr);
    end
    strobe(1'b0, 1'b0, 8'h00);
    tests_run++;
    if (cpu_if.cpu_dout !== 8'h5A || cpu_if.cpu_busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL rd_5a: got dout=%h busy=%b want 5a/1", cpu_if.cpu_dout, cpu_if.cpu_busy);
    end
    wait_idle(cyc);
    tests_run++;
    if (cyc !== 3 || vram_addr !== 14'h2002) begin
      tests_failed++; $display("FAIL rd_addr: got cycles=%0d addr=%h want 3/2002", cyc, vram_addr);
    end
    strobe(1'b0, 1'b0, 8'h00);
    tests_run++;
    if (cpu_if.cpu_dout !== 8'hC3) begin
      tests_failed++; $display("FAIL rd_c3: got dout=%h want c3", cpu_if.cpu_dout);
    end
    wait_idle(cyc);
  endtask

  task automatic test_reg_write();
    strobe(1'b1, 1'b1, 8'h07);
    strobe(1'b1, 1'b1, 8'h82);
    tests_run++;
    if ({reg_we, reg_num, reg_val} !== {1'b1, 4'd2, 8'h07} || vram_we !== 1'b0) begin
      tests_failed++;
      $display("FAIL reg_wr: got we=%b num=%h val=%h vwe=%b want 1/2/07/0",
               reg_we, reg_num, reg_val, vram_we);
    end
    @(posedge clk); #1;
    tests_run++;
    if (reg_we !== 1'b0 || cpu_if.cpu_busy !== 1'b0) begin
      tests_failed++; $display("FAIL reg_pulse: got we=%b busy=%b want 0/0", reg_we, cpu_if.cpu_busy);
    end
  endtask

  task automatic test_cram_write();
    strobe(1'b1, 1'b1, 8'h10);
    strobe(1'b1, 1'b1, 8'hC0);
    strobe(1'b1, 1'b0, 8'h3F);
    tests_run++;
    if ({cram_we, cram_addr, cram_din} !== {1'b1, 5'h10, 8'h3F} || vram_we !== 1'b0) begin
      tests_failed++;
      $display("FAIL cram_wr: got we=%b addr=%h din=%h vwe=%b want 1/10/3f/0",
               cram_we, cram_addr, cram_din, vram_we);
    end
    @(posedge clk); #1;
    tests_run++;
    if (cram_we !== 1'b0 || vram_addr !== 14'h0011) begin
      tests_failed++; $display("FAIL cram_after: got we=%b addr=%h want 0/0011", cram_we, vram_addr);
    end
  endtask

  task automatic test_status_read();
    status_in = 8'hA5;
    strobe(1'b1, 1'b1, 8'h34);
    strobe(1'b0, 1'b1, 8'h00);
    tests_run++;
    if (cpu_if.cpu_dout !== 8'hA5 || status_rd !== 1'b1) begin
      tests_failed++;
      $display("FAIL stat_rd: got dout=%h srd=%b want a5/1", cpu_if.cpu_dout, status_rd);
    end
    status_in = 8'h00;
    @(posedge clk); #1;
    tests_run++;
    if (cpu_if.cpu_dout !== 8'hA5 || status_rd !== 1'b0) begin
      tests_failed++;
      $display("FAIL stat_hold: got dout=%h srd=%b want a5/0", cpu_if.cpu_dout, status_rd);
    end
    strobe(1'b1, 1'b1, 8'h56);
    tests_run++;
    if (vram_addr !== 14'h0056) begin
      tests_failed++; $display("FAIL stat_toggle: got addr=%h want 0056", vram_addr);
    end
    strobe(1'b1, 1'b1, 8'h40);
  endtask

  task automatic test_wrap();
    strobe(1'b1, 1'b1, 8'hFF);
    strobe(1'b1, 1'b1, 8'h7F);
    strobe(1'b1, 1'b0, 8'h11);
    tests_run++;
    if (vram_we !== 1'b1 || vram_addr !== 14'h3FFF) begin
      tests_failed++; $display("FAIL wrap_wr: got we=%b addr=%h want 1/3fff", vram_we, vram_addr);
    end
    @(posedge clk); #1;
    tests_run++;
    if (vram_addr !== 14'h0000) begin
      tests_failed++; $display("FAIL wrap_addr: got addr=%h want 0000", vram_addr);
    end
  endtask

  task automatic test_busy_ignore();
    strobe(1'b1, 1'b1, 8'h00);
    strobe(1'b1, 1'b1, 8'h00);
    strobe(1'b1, 1'b1, 8'h99);
    wait_idle(cyc);
    tests_run++;
    if (cyc > 3 || vram_addr !== 14'h0001) begin
      tests_failed++; $display("FAIL busy_addr: got cycles=%0d addr=%h want <=3/0001", cyc, vram_addr);
    end
    strobe(1'b1, 1'b1, 8'h22);
    tests_run++;
    if (vram_addr !== 14'h0022) begin
      tests_failed++; $display("FAIL busy_ignore: got addr=%h want 0022", vram_addr);
    end
    strobe(1'b1, 1'b1, 8'h40);
  endtask

  task automatic test_reset_abort();
    strobe(1'b1, 1'b1, 8'h00);
    strobe(1'b1, 1'b1, 8'h20);
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    tests_run++;
    if ({vram_addr, vram_we, cram_we, reg_we, status_rd, cpu_if.cpu_busy} !== 19'h0 ||
        cpu_if.cpu_dout !== 8'h00) begin
      tests_failed++;
      $display("FAIL abort_out: got addr=%h busy=%b dout=%h want 0/0/00",
               vram_addr, cpu_if.cpu_busy, cpu_if.cpu_dout);
    end
    #2 reset = 1'b0;
    strobe(1'b0, 1'b0, 8'h00);
    tests_run++;
    if (cpu_if.cpu_dout !== 8'h00) begin
      tests_failed++; $display("FAIL abort_rbuf: got dout=%h want 00", cpu_if.cpu_dout);
    end
    wait_idle(cyc);
    tests_run++;
    if (cyc !== 3 || vram_addr !== 14'h0001) begin
      tests_failed++; $display("FAIL abort_pf: got cycles=%0d addr=%h want 3/0001", cyc, vram_addr);
    end
  endtask

  initial begin
    cpu_if.cpu_sel = 1'b0;
    cpu_if.cpu_wr  = 1'b0;
    cpu_if.cpu_a0  = 1'b0;
    cpu_if.cpu_din = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    reset = 1'b0;
    test_ctrl_latch();
    test_data_write();
    test_prefetch();
    test_reg_write();
    test_cram_write();
    test_status_read();
    test_wrap();
    test_busy_ignore();
    test_reset_abort();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/vdp_cpu_port.md
# vdp_cpu_port

CPU-facing access controller of the VDP: decodes Z80 writes and reads on the VDP data and control ports into VRAM, CRAM and register accesses. It drives port A of the VRAM dual-port RAM, which has synchronous read with one cycle of latency. It also keeps the SMS-style address/code latch, the two-byte control-write toggle and the read-ahead buffer. Downstream, it feeds the VRAM RAM, the CRAM and the VDP register file.

## Interface
Parameters:
- `VRAM_AW`, default 14: VRAM address width. Address wraps at 2**VRAM_AW.
- `CRAM_AW`, default 5: CRAM address width. Uses the low bits of the address latch.

Ports:
- `clk` in, 1 bit: single system clock, rising edge.
- `reset` in, 1 bit: asynchronous, active-high reset.
- `cpu_sel` in, 1 bit: one-cycle access strobe.
- `cpu_wr` in, 1 bit: 1 = write, 0 = read. Sampled with `cpu_sel`.
- `cpu_a0` in, 1 bit: 0 = data port, 1 = control port.
- `cpu_din` in, 8 bits: CPU write data.
- `cpu_dout` out, 8 bits: read data. Registered; valid the cycle after a read strobe.
- `cpu_busy` out, 1 bit: high while a VRAM prefetch is in flight.
- `status_in` in, 8 bits: VDP status byte, returned on control reads.
- `status_rd` out, 1 bit: one-cycle pulse on a control read, used to clear status flags.
- `vram_addr` out, VRAM_AW bits: drives dpram `address_a`.
- `vram_din` out, 8 bits: drives `data_a`.
- `vram_we` out, 1 bit: drives `wren_a`.
- `vram_q` in, 8 bits: from `q_a`.
- `cram_addr` out, CRAM_AW bits: CRAM write address.
- `cram_din` out, 8 bits: CRAM write data.
- `cram_we` out, 1 bit: CRAM write strobe.
- `reg_num` out, 4 bits: VDP register number.
- `reg_val` out, 8 bits: VDP register value.
- `reg_we` out, 1 bit: VDP register write strobe.

## Operation
- State held: `addr` (VRAM_AW bits), `code` (2 bits), `second` toggle, `rbuf` (8 bits), FSM.
- **Control write, `second`=0:** `addr[7:0]` <= din; `second` <= 1.
- **Control write, `second`=1:**
  - `addr[13:8]` <= din[5:0]; `code` <= din[7:6]; `second` <= 0.
  - `code`=0: start a prefetch.
  - `code`=2: one-cycle `reg_we` with `reg_num`=din[3:0] and `reg_val`=`addr[7:0]`.
  - `code`=1 and `code`=3: latch only.
- **Data write:**
  - `second` <= 0; `rbuf` <= din.
  - `code`=3: `cram_we` at `addr[CRAM_AW-1:0]`.
  - Otherwise: `vram_we` at `addr`.
  - Then `addr` <= `addr`+1.
- **Data read:** `cpu_dout` <= `rbuf`; `second` <= 0; start a prefetch.
- **Control read:** `cpu_dout` <= `status_in`; `status_rd` pulses; `second` <= 0.
- **Prefetch FSM:** IDLE -> RD_ADDR -> RD_WAIT -> RD_CAP -> IDLE.
  - RD_ADDR drives `vram_addr`=`addr` with `vram_we`=0.
  - RD_WAIT waits for dpram `q_a`.
  - RD_CAP does `rbuf` <= `vram_q` and `addr` <= `addr`+1.
- **Address wrap:** all increments are modulo 2**VRAM_AW, so 0x3FFF+1 = 0x0000.

## Timing
- **Reset:** every output and every state register is 0; FSM is IDLE.
- **Write strobes:** `vram_we`, `cram_we` and `reg_we` are registered single-cycle pulses, asserted the cycle after the `cpu_sel` edge. Address and data are stable in the same cycle.
- **`cpu_dout`:** valid 1 cycle after a read strobe and held until the next read.
- **Prefetch:** `cpu_busy` rises the cycle after the triggering strobe and falls after RD_CAP. Latency is 3 cycles; a new `rbuf` is visible from cycle 4.
- **Strobes while busy:** `cpu_sel` while `cpu_busy`=1 is ignored entirely, with no state change. The CPU wrapper must wait states on `cpu_busy`.
- **Idle VRAM port:** outside writes and RD_ADDR, `vram_addr` holds `addr` and `vram_we`=0.
- **Reset during prefetch:** aborts immediately; `rbuf`=0; no increment.

## Structure
- Shared package `vdp_pkg` holds:
  - code constants: CODE_VRD=0, CODE_VWR=1, CODE_REG=2, CODE_CRAM=3;
  - the prefetch FSM state enum;
  - VRAM_AW and CRAM_AW defaults.
- No sub-module: a single flat block.

## Test plan
- Control writes 0x34 then 0x52 -> `addr`=0x1234, `code`=1, `second`=0, no RAM strobe.
- After that setup, data writes 0xAA, 0xBB -> `vram_we` at 0x1234=0xAA, then 0x1235=0xBB; `addr`=0x1236.
- Preload 0x2000=0x5A and 0x2001=0xC3; control 0x00, 0x20 -> `cpu_busy` for 3 cycles, `rbuf`=0x5A. Data read -> `cpu_dout`=0x5A, then `rbuf`=0xC3, `addr`=0x2002.
- Control 0x07 then 0x82 -> `reg_we` with `reg_num`=2, `reg_val`=0x07. Control 0x10, 0xC0, then data 0x3F -> `cram_we` at 0x10 with 0x3F.
- Control write 0x34, then control read -> `cpu_dout`=`status_in`, `status_rd` pulses, `second`=0. Next control write lands in the low byte.
- Wrap and abort:
  - Write at `addr` 0x3FFF -> `addr`=0x0000.
  - Strobe during busy -> ignored.
  - `reset` during RD_WAIT -> all outputs 0, FSM IDLE.
